cache_fill_responder: RTL
=========================

CACHE_FILL_RESPONDER -- requirements
Module: cache_fill_responder

Interface
REQ-001 Parameter ADDRBITS, default 12: backing-store word-address width, giving 2^ADDRBITS 32-bit words.
REQ-002 Parameter FILL_DELAY, default 2: extra idle cycles inserted before the first fill beat, to emulate SDRAM CAS latency.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req  in  1  request from the cache; held high by the requester until fill (read) or wr_ack (write).
REQ-006 rw  in  1  1 = line fill (read), 0 = word write; sampled with req.
REQ-007 addr  in  32  byte address; only bits [ADDRBITS+1:2] are used.
REQ-008 wr_data  in  32  write data; sampled with req.
REQ-009 wr_bytesel  in  4  byte enables for wr_data, bit n selects byte n; sampled with req.
REQ-010 fill  out  1  one-cycle strobe marking the first beat of a fill burst.
REQ-011 rd_data  out  16  fill burst halfword stream.
REQ-012 wr_ack  out  1  one-cycle write completion pulse.
REQ-013 busy  out  1  high whenever not in IDLE.
REQ-014 mem_addr  out  ADDRBITS  backing-store word address.
REQ-015 mem_rd  out  1  backing-store read enable; mem_q is valid on the cycle after mem_rd.
REQ-016 mem_q  in  32  backing-store read data.
REQ-017 mem_we, mem_wdata[31:0], mem_bytesel[3:0]  out  backing-store write port.

Function
REQ-018 States: IDLE, DELAY, PREFETCH, BURST, WRITE, WRACK. req is sampled only in IDLE.
REQ-019 IDLE with req=1, rw=1: latch line = addr[ADDRBITS+1:4] and crit = addr[3:2]; busy rises next cycle.
REQ-020 DELAY lasts exactly FILL_DELAY cycles, including 0; PREFETCH then issues mem_rd for {line,crit}.
REQ-021 fill shall be high exactly FILL_DELAY+2 cycles after the accepting IDLE cycle, for one cycle.
REQ-022 The burst is 8 consecutive beats; the first coincides with fill, and there are no gaps.
REQ-023 Beat 2i carries word[(crit+i) mod 4][31:16]; beat 2i+1 carries word[(crit+i) mod 4][15:0], for i = 0..3. This is critical word first, high half first, wrapping within the 4-word line.
REQ-024 mem_rd for each following word is issued early enough that every beat is valid; line address bits never change during the burst.
REQ-025 After beat 7 the block returns to IDLE; a req still high on that cycle is not accepted until the next IDLE cycle.
REQ-026 IDLE with req=1, rw=0: latch address, wr_data and wr_bytesel, then enter WRITE.
REQ-027 WRITE (one cycle): mem_we=1, mem_addr = latched word address, mem_wdata/mem_bytesel = latched values; wr_ack=1 in the same cycle.
REQ-028 WRACK: wait for req=0, then return to IDLE; no second write occurs while req is held.
REQ-029 A write with wr_bytesel=0000 still completes the handshake; mem_we is asserted with all enables low.
REQ-030 Address bits above ADDRBITS+1 are ignored, so accesses alias modulo the store size.
REQ-031 rd_data = 0 outside BURST; mem_we, mem_rd, fill and wr_ack are low except as stated above.

Reset
REQ-032 reset=1 immediately forces IDLE regardless of state, including mid-burst or mid-write.
REQ-033 On reset, fill, wr_ack, busy, mem_rd and mem_we = 0; rd_data, mem_addr, mem_wdata and mem_bytesel = 0.
REQ-034 Releasing reset never produces a partial burst or spurious write; the first action waits for req in IDLE.

Verification
REQ-035 Preload line 0x10 with words 0x11112222, 0x33334444, 0x55556666, 0x77778888; read req addr=0x108, FILL_DELAY=2 -> fill 4 cycles after accept; beats 5555,6666,7777,8888,1111,2222,3333,4444.
REQ-036 Same line, crit=0, FILL_DELAY=0 -> fill 2 cycles after accept; beats in ascending order 1111..8888 with no gaps.
REQ-037 Write addr=0x104, wr_data=0xAABBCCDD, wr_bytesel=0101 with req held for 5 cycles -> exactly one mem_we and one wr_ack; a following fill returns word1 = 0x33BB44DD.
REQ-038 Assert reset during beat 3 -> fill, rd_data and busy drop asynchronously; a new read after release returns a full, correct 8-beat burst.
REQ-039 Read at addr = 2^(ADDRBITS+2) + 0x108 -> identical beats to REQ-035 (aliasing).
REQ-040 Keep req high continuously across two back-to-back reads -> the second accept occurs no earlier than the IDLE cycle after beat 7, with busy low for exactly that one cycle.

Source files
------------

// File: rtl/cache_fill_responder.sv
// Backing-store responder for a cache: critical-word-first 8-beat halfword line fills
// and single-word byte-masked writes with a four-phase req/ack handshake.
module cache_fill_responder #(
    parameter int ADDRBITS   = 12,
    parameter int FILL_DELAY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                rw,
    input  logic [31:0]         addr,
    input  logic [31:0]         wr_data,
    input  logic [3:0]          wr_bytesel,
    output logic                fill,
    output logic [15:0]         rd_data,
    output logic                wr_ack,
    output logic                busy,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic                mem_rd,
    input  logic [31:0]         mem_q,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_bytesel
);

    localparam int LW = ADDRBITS - 2;
    localparam int CW = $clog2(FILL_DELAY + 2);
    localparam logic [CW-1:0] DLY_LAST = CW'((FILL_DELAY > 0) ? FILL_DELAY - 1 : 0);
    localparam logic [CW-1:0] DLY_ONE  = CW'(32'd1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DELAY    = 3'd1,
        S_PREFETCH = 3'd2,
        S_BURST    = 3'd3,
        S_WRITE    = 3'd4,
        S_WRACK    = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       dly_q, dly_d;
    logic [2:0]          beat_q, beat_d;
    logic [LW-1:0]       line_q, line_d;
    logic [1:0]          crit_q, crit_d;
    logic [15:0]         lo_q, lo_d;
    logic                fill_q, fill_d;
    logic                wr_ack_q, wr_ack_d;
    logic                busy_q, busy_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDRBITS-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_bytesel_q, mem_bytesel_d;
    logic [1:0]          nxt_word_s;
    logic                unused_addr_s;

    // Word fetched on an even beat is the one after the current one, wrapping inside the line.
    assign nxt_word_s    = crit_q + beat_q[2:1] + 2'd1;
    assign unused_addr_s = ^{addr[31:ADDRBITS+2], addr[1:0]};

    // Next-state and next-output logic; strobes are computed one cycle ahead so they leave registers.
    always_comb begin
        state_d       = state_q;
        dly_d         = dly_q;
        beat_d        = beat_q;
        line_d        = line_q;
        crit_d        = crit_q;
        lo_d          = lo_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_bytesel_d = mem_bytesel_q;
        mem_rd_d      = 1'b0;
        mem_we_d      = 1'b0;
        wr_ack_d      = 1'b0;
        fill_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (rw) begin
                        line_d = addr[ADDRBITS+1:4];
                        crit_d = addr[3:2];
                        dly_d  = '0;
                        if (FILL_DELAY == 0) begin
                            state_d    = S_PREFETCH;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr[ADDRBITS+1:2];
                        end else begin
                            state_d = S_DELAY;
                        end
                    end else begin
                        mem_addr_d    = addr[ADDRBITS+1:2];
                        mem_wdata_d   = wr_data;
                        mem_bytesel_d = wr_bytesel;
                        mem_we_d      = 1'b1;
                        wr_ack_d      = 1'b1;
                        state_d       = S_WRITE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DELAY: begin
                dly_d = dly_q + DLY_ONE;
                if (dly_q == DLY_LAST) begin
                    state_d    = S_PREFETCH;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {line_q, crit_q};
                end else begin
                    state_d = S_DELAY;
                end
            end
            S_PREFETCH: begin
                beat_d  = 3'd0;
                fill_d  = 1'b1;
                state_d = S_BURST;
            end
            S_BURST: begin
                beat_d = beat_q + 3'd1;
                if (!beat_q[0]) begin
                    lo_d = mem_q[15:0];
                end else begin
                    lo_d = lo_q;
                end
                // mem_q holds until the next read, so the read for word i+1 goes out on the odd beat.
                if (!beat_q[0] && (beat_q != 3'd6)) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {line_q, nxt_word_s};
                end else begin
                    mem_rd_d = 1'b0;
                end
                if (beat_q == 3'd7) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BURST;
                end
            end
            S_WRITE: begin
                state_d = S_WRACK;
            end
            S_WRACK: begin
                if (req) begin
                    state_d = S_WRACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            dly_q         <= '0;
            beat_q        <= 3'd0;
            line_q        <= '0;
            crit_q        <= 2'd0;
            lo_q          <= 16'd0;
            fill_q        <= 1'b0;
            wr_ack_q      <= 1'b0;
            busy_q        <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 32'd0;
            mem_bytesel_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            dly_q         <= dly_d;
            beat_q        <= beat_d;
            line_q        <= line_d;
            crit_q        <= crit_d;
            lo_q          <= lo_d;
            fill_q        <= fill_d;
            wr_ack_q      <= wr_ack_d;
            busy_q        <= busy_d;
            mem_rd_q      <= mem_rd_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_bytesel_q <= mem_bytesel_d;
        end
    end

    // The high half comes straight from the store on even beats; the low half from the held copy.
    always_comb begin
        if (state_q == S_BURST) begin
            rd_data = beat_q[0] ? lo_q : mem_q[31:16];
        end else begin
            rd_data = 16'd0;
        end
    end

    assign fill        = fill_q;
    assign wr_ack      = wr_ack_q;
    assign busy        = busy_q;
    assign mem_rd      = mem_rd_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_bytesel = mem_bytesel_q;

endmodule
